mod_mult: RTL and testbench
===========================

MOD_MULT -- requirements
Module: mod_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  multiplicand; a < n is required.
REQ-006 SHALL have port b  input  WIDTH  multiplier; b < n is required.
REQ-007 SHALL have port n  input  WIDTH  modulus.
REQ-008 SHALL have port busy  output  1  high while a request is in progress.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port err  output  1  n==0 flag, valid with done.
REQ-011 SHALL have port result  output  WIDTH  (a*b) mod n, valid from done onward.

Function
REQ-012 SHALL implement an interleaved (Blakley) modular multiplier with one bit of a per cycle, MSB first.
REQ-013 SHALL latch a, b and n into internal registers when start is accepted; later input changes SHALL have no effect on the running request.
REQ-014 SHALL use states IDLE, RUN and DONE.
REQ-015 SHALL handle IDLE + start as follows when latched n != 0: go to RUN, clear the accumulator R, set bit counter = WIDTH-1, set busy=1.
REQ-016 SHALL handle RUN as follows each cycle: R <= reduce(2R + (a[cnt] ? b : 0)), where reduce subtracts n up to twice while the value is >= n.
REQ-017 SHALL compute the RUN intermediate in WIDTH+2 bits with no truncation before reduction.
REQ-018 SHALL, in RUN with cnt==0, go to DONE and load result <= the reduced value.
REQ-019 SHALL otherwise decrement cnt in RUN.
REQ-020 SHALL hold done=1 and busy=0 for exactly one cycle in DONE, then return to IDLE.
REQ-021 SHALL give a latency of WIDTH+1 cycles from the start-accept edge to the edge that raises done.
REQ-022 SHALL handle IDLE + start with n==0 as follows: go directly to DONE with result=0 and err=1; err SHALL otherwise be 0.
REQ-023 SHALL ignore start while in RUN or DONE, with no queuing.
REQ-024 SHALL hold result stable from done until the next accepted request completes.
REQ-025 SHALL leave results for inputs with a >= n or b >= n unspecified, while still completing in WIDTH+1 cycles.

Reset
REQ-026 SHALL, on rst=1 at any time including mid-RUN, immediately force state=IDLE, busy=0, done=0, err=0, result=0, R=0 and cnt=0.
REQ-027 SHALL discard any aborted request, with no done pulse for it.
REQ-028 SHALL not accept start in a cycle where rst is high.

Structure
REQ-029 SHALL place the state enum type (IDLE/RUN/DONE) and the default WIDTH constant in a shared package alu_pkg.
REQ-030 SHALL place the combinational per-bit step (double, conditional add of b, two conditional subtracts of n) in one sub-module, mod_mult_step.
REQ-031 SHALL have mod_mult_step perform its subtractions with the existing ALU add/sub datapath (inverted operand, cin=1).
REQ-032 SHALL keep the FSM, counter and operand registers in mod_mult itself.

Verification (WIDTH=8)
REQ-033 SHALL verify: a=7, b=5, n=11, start pulse -> done exactly 9 cycles after the accept edge, result=2, err=0.
REQ-034 SHALL verify: a=200, b=150, n=251 -> result=131; then a=254, b=254, n=255 -> result=1, covering the maximum intermediate value.
REQ-035 SHALL verify: a=0, b=123, n=200 -> result=0; and n=1, a=b=0 -> result=0.
REQ-036 SHALL verify: n=0 -> done one cycle after accept, err=1, result=0, busy never high.
REQ-037 SHALL verify: start re-pulsed during RUN with different operands -> ignored, first result returned, exactly one done pulse.
REQ-038 SHALL verify: rst asserted at the 4th RUN cycle -> outputs zero at once, no done; a fresh request afterwards (7, 5, 11) -> result=2.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU types: controller state encoding and default datapath width.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mod_mult_if.sv
// Request/response bundle for the modular multiplier: operands in, status and result out.
interface mod_mult_if
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] n;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;

    modport master (output start, a, b, n, input busy, done, err, result);
    modport slave  (input start, a, b, n, output busy, done, err, result);
endinterface

// File: rtl/mod_mult_step.sv
// One Blakley step: reduce(2r + (a_bit ? b : 0)) mod n, purely combinational (zero latency).
// No flow control; the caller sequences one step per cycle.
module mod_mult_step
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    input  logic             a_bit,
    output logic [WIDTH-1:0] r_next
);
    localparam int XW = WIDTH + 2;
    localparam logic [XW:0] CIN_ONE = 1;

    logic [XW-1:0] sum;
    logic [XW-1:0] n_x;
    logic [XW-1:0] t1;
    logic [XW-1:0] t2;
    logic [XW:0]   d1;
    logic [XW:0]   d2;

    // Subtract via x + ~y + 1; the carry out is set exactly when x >= y.
    always_comb begin
        sum    = XW'({r, 1'b0}) + (a_bit ? XW'(b) : '0);
        n_x    = XW'(n);
        d1     = {1'b0, sum} + {1'b0, ~n_x} + CIN_ONE;
        t1     = d1[XW] ? d1[XW-1:0] : sum;
        d2     = {1'b0, t1} + {1'b0, ~n_x} + CIN_ONE;
        t2     = d2[XW] ? d2[XW-1:0] : t1;
        r_next = t2[WIDTH-1:0];
    end
endmodule

// File: rtl/mod_mult.sv
// Interleaved modular multiplier, one bit of a per cycle MSB first; done is seen WIDTH+1 cycles after accept.
// start is only honoured in IDLE; requests arriving while busy or in DONE are dropped.
module mod_mult
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic     clk,
    input  logic     rst,
    mod_mult_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] step_out;

    mod_mult_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_q),
        .b      (b_q),
        .n      (n_q),
        .a_bit  (a_q[cnt_q]),
        .r_next (step_out)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        r_d      = r_q;
        a_d      = a_q;
        b_d      = b_q;
        n_d      = n_q;
        result_d = result_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d   = bus.a;
                    b_d   = bus.b;
                    n_d   = bus.n;
                    r_d   = '0;
                    cnt_d = CW'(WIDTH - 1);
                    // A zero modulus has no meaningful residue; flag it and finish at once.
                    if (bus.n == '0) begin
                        state_d  = DONE;
                        result_d = '0;
                        err_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                r_d = step_out;
                if (cnt_q == '0) begin
                    state_d  = DONE;
                    result_d = step_out;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            r_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            r_q      <= r_d;
            a_q      <= a_d;
            b_q      <= b_d;
            n_q      <= n_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign bus.busy   = (state_q == RUN);
    assign bus.done   = (state_q == DONE);
    assign bus.err    = err_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_mod_mult.sv
// Directed checks of mod_mult at WIDTH=8 against hand-computed residues and cycle counts.
module tb_mod_mult;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    bit   busy_seen = 0;
    int   lat;
    int   snap;

    mod_mult_if #(.WIDTH(W)) bus ();

    mod_mult #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.done) done_cnt++;
        if (bus.busy) busy_seen = 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle, then count negedges until done is seen (bounded).
    task automatic req(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] nv, output int l);
        @(negedge clk);
        bus.start = 1'b1; bus.a = av; bus.b = bv; bus.n = nv;
        @(negedge clk);
        bus.start = 1'b0;
        l = 1;
        while (bus.done !== 1'b1 && l < 40) begin
            @(negedge clk);
            l++;
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.n = '0;
        #1;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_err", int'(bus.err), 0);
        check("rst_result", int'(bus.result), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // 7*5 mod 11 = 35 mod 11 = 2
        req(8'd7, 8'd5, 8'd11, lat);
        check("t1_latency", lat, 9);
        check("t1_result", int'(bus.result), 2);
        check("t1_err", int'(bus.err), 0);
        check("t1_busy_at_done", int'(bus.busy), 0);
        @(negedge clk);
        check("t1_done_one_cycle", int'(bus.done), 0);
        @(negedge clk); @(negedge clk);
        check("t1_result_hold", int'(bus.result), 2);

        // 30000 mod 251 = 131
        req(8'd200, 8'd150, 8'd251, lat);
        check("t2_latency", lat, 9);
        check("t2_result", int'(bus.result), 131);
        // 254*254 = 64516 = 253*255 + 1
        req(8'd254, 8'd254, 8'd255, lat);
        check("t3_result", int'(bus.result), 1);
        req(8'd0, 8'd123, 8'd200, lat);
        check("t4_result", int'(bus.result), 0);
        req(8'd0, 8'd0, 8'd1, lat);
        check("t5_result", int'(bus.result), 0);
        check("t5_latency", lat, 9);

        // Zero modulus: immediate done with err
        @(negedge clk);
        busy_seen = 0;
        req(8'd3, 8'd4, 8'd0, lat);
        check("t6_latency", lat, 1);
        check("t6_err", int'(bus.err), 1);
        check("t6_result", int'(bus.result), 0);
        check("t6_busy_seen", int'(busy_seen), 0);
        @(negedge clk);
        check("t6_err_clears", int'(bus.err), 0);

        // Re-pulsed start during RUN with new operands is ignored
        @(negedge clk);
        snap = done_cnt;
        bus.start = 1'b1; bus.a = 8'd7; bus.b = 8'd5; bus.n = 8'd11;
        @(negedge clk);
        bus.start = 1'b0; bus.a = 8'd200; bus.b = 8'd150; bus.n = 8'd251;
        @(negedge clk); @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 16; i++) @(negedge clk);
        #1;
        check("t7_result", int'(bus.result), 2);
        check("t7_done_pulses", done_cnt - snap, 1);
        check("t7_idle", int'(bus.busy), 0);

        // Reset during the 4th RUN cycle aborts without a done pulse
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'd200; bus.b = 8'd150; bus.n = 8'd251;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("t8_busy_before_rst", int'(bus.busy), 1);
        snap = done_cnt;
        rst = 1'b1;
        #1;
        check("t8_rst_busy", int'(bus.busy), 0);
        check("t8_rst_done", int'(bus.done), 0);
        check("t8_rst_err", int'(bus.err), 0);
        check("t8_rst_result", int'(bus.result), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) @(negedge clk);
        #1;
        check("t8_no_done", done_cnt - snap, 0);
        req(8'd7, 8'd5, 8'd11, lat);
        check("t8_fresh_latency", lat, 9);
        check("t8_fresh_result", int'(bus.result), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
